// File: rtl/ras_ctrl.sv
// ras_ctrl: return-address-stack controller for a RISC-V fetch stage.
// Infers calls/returns from JAL/JALR link-register usage, predicts return
// targets from a circular stack, and checkpoints the stack top at every
// conditional branch so a mispredict can roll the stack back.

module ras_ctrl #(
  parameter int RAS_DEPTH  = 8,
  parameter int CKPT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_instr,
  output logic        fetch_ready,
  output logic        pred_valid,
  output logic [31:0] pred_target,
  input  logic        br_resolve,
  input  logic        br_mispred,
  input  logic        flush,
  output logic        ckpt_full,
  output logic        ras_empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(CKPT_DEPTH);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_PUSH,
    ACT_POP,
    ACT_POPPUSH
  } ras_act_e;

  typedef struct packed {
    logic [PW-1:0] tp;
    logic [PW:0]   occ;
    logic [31:0]   val;
  } ckpt_t;

  // Storage arrays: deliberately not reset, occupancy decides what is live.
  logic [31:0] stack_mem [RAS_DEPTH];
  ckpt_t       ckpt_mem  [CKPT_DEPTH];

  logic [PW-1:0] top_q, top_d;
  logic [PW:0]   occ_q, occ_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW:0]   ck_cnt_q, ck_cnt_d;

  logic [6:0]  opcode;
  logic [4:0]  rd_idx;
  logic [4:0]  rs1_idx;
  logic        rd_link;
  logic        rs1_link;
  ras_act_e    act;
  logic        is_branch;
  logic        accept;
  logic        enqueue;
  logic        ck_nonempty;
  logic        resolve_ok;
  logic        restore;
  logic [31:0] top_val;
  logic [31:0] link_addr;
  ckpt_t       ckpt_head;
  ckpt_t       ckpt_new;

  logic          stack_we;
  logic [PW-1:0] stack_widx;
  logic [31:0]   stack_wdata;

  logic unused_instr_bits;

  assign opcode   = fetch_instr[6:0];
  assign rd_idx   = fetch_instr[11:7];
  assign rs1_idx  = fetch_instr[19:15];
  assign rd_link  = (rd_idx == 5'd1) || (rd_idx == 5'd5);
  assign rs1_link = (rs1_idx == 5'd1) || (rs1_idx == 5'd5);

  assign unused_instr_bits = ^{fetch_instr[31:20], fetch_instr[14:12]};

  assign ras_empty   = (occ_q == '0);
  assign ckpt_full   = (ck_cnt_q == (CW+1)'(CKPT_DEPTH));
  assign fetch_ready = !ckpt_full && !flush && !(br_resolve && br_mispred);
  assign accept      = fetch_valid && fetch_ready;
  assign enqueue     = accept && is_branch;

  assign top_val   = stack_mem[top_q];
  assign link_addr = fetch_pc + 32'd4;
  assign ckpt_head = ckpt_mem[rd_ptr_q];

  assign ck_nonempty = (ck_cnt_q != '0);
  assign resolve_ok  = br_resolve && !br_mispred && ck_nonempty && !flush;
  assign restore     = br_resolve && br_mispred && ck_nonempty && !flush;

  assign ckpt_new.tp  = top_q;
  assign ckpt_new.occ = occ_q;
  assign ckpt_new.val = top_val;

  // Classify the fetched instruction into a stack action from link-register usage.
  always_comb begin
    act       = ACT_NONE;
    is_branch = 1'b0;
    if (opcode == OP_JAL) begin
      if (rd_link) act = ACT_PUSH;
    end else if (opcode == OP_JALR) begin
      case ({rd_link, rs1_link})
        2'b10:   act = ACT_PUSH;
        2'b01:   act = ACT_POP;
        2'b11:   act = (rd_idx == rs1_idx) ? ACT_PUSH : ACT_POPPUSH;
        default: act = ACT_NONE;
      endcase
    end else if (opcode == OP_BRANCH) begin
      is_branch = 1'b1;
    end
  end

  // Return prediction: the current top entry whenever an accepted return finds a live entry.
  always_comb begin
    pred_valid  = 1'b0;
    pred_target = 32'd0;
    if (accept && ((act == ACT_POP) || (act == ACT_POPPUSH)) && !ras_empty) begin
      pred_valid  = 1'b1;
      pred_target = top_val;
    end
  end

  // Next-state: flush beats mispredict rollback, which beats normal fetch/resolve traffic.
  always_comb begin
    top_d       = top_q;
    occ_d       = occ_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    ck_cnt_d    = ck_cnt_q;
    stack_we    = 1'b0;
    stack_widx  = top_q;
    stack_wdata = link_addr;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      ck_cnt_d = '0;
    end else if (restore) begin
      top_d       = ckpt_head.tp;
      occ_d       = ckpt_head.occ;
      stack_we    = 1'b1;
      stack_widx  = ckpt_head.tp;
      stack_wdata = ckpt_head.val;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      ck_cnt_d    = '0;
    end else begin
      if (accept) begin
        case (act)
          ACT_PUSH: begin
            top_d      = top_q + PW'(1);
            stack_we   = 1'b1;
            stack_widx = top_q + PW'(1);
            if (occ_q != (PW+1)'(RAS_DEPTH)) occ_d = occ_q + (PW+1)'(1);
          end
          ACT_POP: begin
            if (!ras_empty) begin
              top_d = top_q - PW'(1);
              occ_d = occ_q - (PW+1)'(1);
            end
          end
          ACT_POPPUSH: begin
            stack_we   = 1'b1;
            stack_widx = top_q;
            if (ras_empty) occ_d = (PW+1)'(1);
          end
          default: begin
          end
        endcase
      end
      if (enqueue)    wr_ptr_d = wr_ptr_q + CW'(1);
      if (resolve_ok) rd_ptr_d = rd_ptr_q + CW'(1);
      case ({enqueue, resolve_ok})
        2'b10:   ck_cnt_d = ck_cnt_q + (CW+1)'(1);
        2'b01:   ck_cnt_d = ck_cnt_q - (CW+1)'(1);
        default: ck_cnt_d = ck_cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_q    <= '0;
      occ_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      ck_cnt_q <= '0;
    end else begin
      top_q    <= top_d;
      occ_q    <= occ_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ck_cnt_q <= ck_cnt_d;
    end
  end

  // Stack entry writes: pushes, in-place overwrites, and rollback of the top entry.
  always_ff @(posedge clk) begin
    if (stack_we) stack_mem[stack_widx] <= stack_wdata;
  end

  // Checkpoint capture of the pre-update stack top for each accepted branch.
  always_ff @(posedge clk) begin
    if (enqueue) ckpt_mem[wr_ptr_q] <= ckpt_new;
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: directed scenarios plus randomized traffic for ras_ctrl,
// checked cycle by cycle against a behavioural stack/checkpoint model.

module tb_ras_ctrl;

  localparam int RAS_DEPTH  = 8;
  localparam int CKPT_DEPTH = 4;

  localparam int A_NONE    = 0;
  localparam int A_PUSH    = 1;
  localparam int A_POP     = 2;
  localparam int A_POPPUSH = 3;
  localparam int A_BRANCH  = 4;

  localparam logic [31:0] BRANCH_INSTR = 32'h0000_0063;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        fetch_ready;
  logic        pred_valid;
  logic [31:0] pred_target;
  logic        br_resolve;
  logic        br_mispred;
  logic        flush;
  logic        ckpt_full;
  logic        ras_empty;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          tp;
    int          occ;
    logic [31:0] val;
  } ck_t;

  logic [31:0] m_mem [RAS_DEPTH];
  int          m_top;
  int          m_occ;
  ck_t         m_ck [$];

  logic        obs_pv;
  logic [31:0] obs_pt;
  logic        obs_ready;
  logic        obs_full;
  logic        obs_empty;

  ras_ctrl #(
    .RAS_DEPTH  (RAS_DEPTH),
    .CKPT_DEPTH (CKPT_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_instr (fetch_instr),
    .fetch_ready (fetch_ready),
    .pred_valid  (pred_valid),
    .pred_target (pred_target),
    .br_resolve  (br_resolve),
    .br_mispred  (br_mispred),
    .flush       (flush),
    .ckpt_full   (ckpt_full),
    .ras_empty   (ras_empty)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] mkJal(input logic [4:0] rd);
    return {20'h0, rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] mkJalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h0, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  function automatic int classify(input logic [31:0] ins);
    logic [4:0] rd;
    logic [4:0] rs1;
    bit rdl;
    bit rsl;
    rd  = ins[11:7];
    rs1 = ins[19:15];
    rdl = (rd == 5'd1) || (rd == 5'd5);
    rsl = (rs1 == 5'd1) || (rs1 == 5'd5);
    if (ins[6:0] == 7'b1101111) return rdl ? A_PUSH : A_NONE;
    if (ins[6:0] == 7'b1100011) return A_BRANCH;
    if (ins[6:0] == 7'b1100111) begin
      if (rdl && !rsl) return A_PUSH;
      if (!rdl && rsl) return A_POP;
      if (rdl && rsl) return (rd == rs1) ? A_PUSH : A_POPPUSH;
    end
    return A_NONE;
  endfunction

  function automatic logic [4:0] pickReg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd5;
      default: return 5'd7;
    endcase
  endfunction

  // Drive one cycle of inputs, check all outputs against the model, then advance the model.
  task automatic applyStimulus(input logic fv, input logic [31:0] pc, input logic [31:0] instr,
                               input logic res, input logic mis, input logic fl);
    int          act;
    bit          acc;
    bit          e_full;
    bit          e_empty;
    bit          e_ready;
    bit          e_pv;
    logic [31:0] e_pt;
    ck_t         snap;

    fetch_valid = fv;
    fetch_pc    = pc;
    fetch_instr = instr;
    br_resolve  = res;
    br_mispred  = mis;
    flush       = fl;

    act     = classify(instr);
    e_full  = (m_ck.size() == CKPT_DEPTH);
    e_empty = (m_occ == 0);
    e_ready = !e_full && !fl && !(res && mis);
    acc     = fv && e_ready;
    e_pv    = acc && (act == A_POP || act == A_POPPUSH) && (m_occ > 0);
    e_pt    = e_pv ? m_mem[m_top] : 32'd0;

    @(negedge clk);
    obs_pv    = pred_valid;
    obs_pt    = pred_target;
    obs_ready = fetch_ready;
    obs_full  = ckpt_full;
    obs_empty = ras_empty;
    checkOutput("fetch_ready", 32'(obs_ready), 32'(e_ready));
    checkOutput("ckpt_full",   32'(obs_full),  32'(e_full));
    checkOutput("ras_empty",   32'(obs_empty), 32'(e_empty));
    checkOutput("pred_valid",  32'(obs_pv),    32'(e_pv));
    checkOutput("pred_target", obs_pt,         e_pt);

    snap.tp  = m_top;
    snap.occ = m_occ;
    snap.val = m_mem[m_top];
    if (fl) begin
      m_ck.delete();
    end else if (res && mis) begin
      if (m_ck.size() > 0) begin
        m_top        = m_ck[0].tp;
        m_occ        = m_ck[0].occ;
        m_mem[m_top] = m_ck[0].val;
        m_ck.delete();
      end
    end else begin
      if (acc) begin
        case (act)
          A_PUSH: begin
            m_top        = (m_top + 1) % RAS_DEPTH;
            m_mem[m_top] = pc + 32'd4;
            if (m_occ < RAS_DEPTH) m_occ++;
          end
          A_POP: begin
            if (m_occ > 0) begin
              m_top = (m_top + RAS_DEPTH - 1) % RAS_DEPTH;
              m_occ--;
            end
          end
          A_POPPUSH: begin
            m_mem[m_top] = pc + 32'd4;
            if (m_occ == 0) m_occ = 1;
          end
          default: begin
          end
        endcase
      end
      if (res && m_ck.size() > 0) void'(m_ck.pop_front());
      if (acc && act == A_BRANCH) m_ck.push_back(snap);
    end

    @(posedge clk);
    #1;
  endtask

  // Assert reset between clock edges and check that status clears without a clock.
  task automatic doReset();
    fetch_valid = 1'b0;
    fetch_pc    = 32'd0;
    fetch_instr = NOP_INSTR;
    br_resolve  = 1'b0;
    br_mispred  = 1'b0;
    flush       = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_ras_empty",   32'(ras_empty),   32'd1);
    checkOutput("rst_ckpt_full",   32'(ckpt_full),   32'd0);
    checkOutput("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    checkOutput("rst_pred_valid",  32'(pred_valid),  32'd0);
    checkOutput("rst_pred_target", pred_target,      32'd0);
    m_top = 0;
    m_occ = 0;
    m_ck.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] rpc;
    logic [31:0] rword;
    logic [31:0] rinstr;
    logic        rres;
    logic        rmis;
    logic        rfl;

    rst         = 1'b0;
    fetch_valid = 1'b0;
    fetch_pc    = 32'd0;
    fetch_instr = NOP_INSTR;
    br_resolve  = 1'b0;
    br_mispred  = 1'b0;
    flush       = 1'b0;
    m_top       = 0;
    m_occ       = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Single call/return pair.
    doReset();
    applyStimulus(1'b1, 32'h1000, mkJal(5'd1), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1004, mkJalr(5'd0, 5'd1), 1'b0, 1'b0, 1'b0);
    checkOutput("ret_pv", 32'(obs_pv), 32'd1);
    checkOutput("ret_pt", obs_pt, 32'h1004);
    applyStimulus(1'b0, 32'd0, NOP_INSTR, 1'b0, 1'b0, 1'b0);
    checkOutput("ret_empty_after", 32'(obs_empty), 32'd1);

    // Overflow: nine calls into an eight-entry stack, then nine returns.
    doReset();
    for (int i = 0; i < 9; i++)
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), mkJal(5'd1), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 32'h800, mkJalr(5'd0, 5'd1), 1'b0, 1'b0, 1'b0);
      if (i < 8) begin
        checkOutput("ovf_pv", 32'(obs_pv), 32'd1);
        checkOutput("ovf_pt", obs_pt, 32'h124 - 32'(4 * i));
      end else begin
        checkOutput("ovf_last_pv", 32'(obs_pv), 32'd0);
      end
    end

    // Mispredict rollback restores the clobbered top entry.
    doReset();
    applyStimulus(1'b1, 32'h200, mkJal(5'd1), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h204, BRANCH_INSTR, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h208, mkJalr(5'd0, 5'd1), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h300, mkJal(5'd1), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, NOP_INSTR, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h400, mkJalr(5'd0, 5'd1), 1'b0, 1'b0, 1'b0);
    checkOutput("rollback_pv", 32'(obs_pv), 32'd1);
    checkOutput("rollback_pt", obs_pt, 32'h204);

    // Checkpoint FIFO fill and drain by one.
    doReset();
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 32'h40 + 32'(4 * i), BRANCH_INSTR, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h50, BRANCH_INSTR, 1'b0, 1'b0, 1'b0);
    checkOutput("full_flag", 32'(obs_full), 32'd1);
    checkOutput("full_ready", 32'(obs_ready), 32'd0);
    applyStimulus(1'b0, 32'd0, NOP_INSTR, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, NOP_INSTR, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_flag", 32'(obs_full), 32'd0);

    // Pop-then-push with different link registers.
    doReset();
    applyStimulus(1'b1, 32'h3fc, mkJal(5'd1), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h500, mkJalr(5'd5, 5'd1), 1'b0, 1'b0, 1'b0);
    checkOutput("swap_pt", obs_pt, 32'h400);
    applyStimulus(1'b1, 32'h600, mkJalr(5'd0, 5'd1), 1'b0, 1'b0, 1'b0);
    checkOutput("swap_new_top", obs_pt, 32'h504);
    applyStimulus(1'b0, 32'd0, NOP_INSTR, 1'b0, 1'b0, 1'b0);
    checkOutput("swap_occ_one", 32'(obs_empty), 32'd1);

    // Reset in the middle of live speculative state.
    doReset();
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h700 + 32'(4 * i), mkJal(5'd1), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 32'h740 + 32'(4 * i), BRANCH_INSTR, 1'b0, 1'b0, 1'b0);
    doReset();
    applyStimulus(1'b1, 32'h780, mkJalr(5'd0, 5'd1), 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_pop_pv", 32'(obs_pv), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        doReset();
      end else begin
        rword = $urandom();
        rpc   = {rword[31:2], 2'b00};
        case ($urandom_range(0, 5))
          0, 1:    rinstr = mkJal(pickReg());
          2, 3:    rinstr = mkJalr(pickReg(), pickReg());
          4:       rinstr = BRANCH_INSTR;
          default: rinstr = NOP_INSTR;
        endcase
        rres = ($urandom_range(0, 3) == 0);
        rmis = rres && ($urandom_range(0, 7) == 0);
        rfl  = ($urandom_range(0, 39) == 0);
        applyStimulus(($urandom_range(0, 3) != 0), rpc, rinstr, rres, rmis, rfl);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
